int_ctrl: RTL and testbench

Interrupt controller that sits directly upstream of the PC-select mux and the return-address stack (pila) of the 8-bit CPU. It latches edges on NSRC external interrupt lines and arbitrates them by fixed priority. For each taken interrupt it produces a one-cycle take pulse carrying a 10-bit vector address, plus a push request carrying the return PC. On return-from-interrupt it issues the matching pop request. One interrupt is serviced at a time; there is no nesting.

---
 rtl/int_pkg.sv | 18 +
 rtl/sync_edge.sv | 30 +++
 rtl/int_ctrl.sv | 131 +++++++++++++
 tb/tb_int_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
// int_pkg: definitions shared by the interrupt controller.
//   int_state_t    - controller FSM states (IDLE, TAKE, SERVICE)
//   NSRC_DEF       - default number of interrupt sources
//   VEC_BASE_DEF   - default vector address of source 0
//   VEC_STRIDE_DEF - default address distance between consecutive vectors
package int_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TAKE    = 2'd1,
      SERVICE = 2'd2
   } int_state_t;

   localparam int         NSRC_DEF       = 4;
   localparam logic [9:0] VEC_BASE_DEF   = 10'h3F0;
   localparam int         VEC_STRIDE_DEF = 4;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: two-flop synchronizer for one asynchronous interrupt line,
// followed by a third flop used to detect a rising edge.
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high; clears all three flops
//   din   - asynchronous level input
//   rise  - one-cycle pulse after a synchronized 0->1 transition
module sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic rise
);

   logic s1, s2, s3;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= din;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: fixed-priority, non-nesting interrupt controller feeding the
// PC-select mux and the return-address stack.
//   clk, reset      - system clock (rising edge), async active-high reset
//   irq             - asynchronous interrupt lines, rising edge = request
//   ei, di          - enable / disable interrupts (di wins)
//   mask_we/mask_wd - load the mask register (1 = source masked)
//   reti            - return from interrupt (honoured only in SERVICE)
//   pc_next         - return address pushed on a take
//   int_take, push  - one-cycle take pulse / stack push request
//   vector          - VEC_BASE + idx*VEC_STRIDE of the taken source
//   push_data       - pc_next during the take cycle
//   pop             - stack pop request on an accepted reti
//   ack             - one-hot acknowledge of the taken source
//   mask, pending   - current mask register / latched requests
//   in_service      - high while a handler runs
module int_ctrl
   import int_pkg::*;
#(
   parameter int         NSRC       = NSRC_DEF,
   parameter logic [9:0] VEC_BASE   = VEC_BASE_DEF,
   parameter int         VEC_STRIDE = VEC_STRIDE_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] irq,
   input  logic            ei,
   input  logic            di,
   input  logic            mask_we,
   input  logic [NSRC-1:0] mask_wd,
   input  logic            reti,
   input  logic [9:0]      pc_next,
   output logic            int_take,
   output logic [9:0]      vector,
   output logic            push,
   output logic [9:0]      push_data,
   output logic            pop,
   output logic [NSRC-1:0] ack,
   output logic [NSRC-1:0] mask,
   output logic [NSRC-1:0] pending,
   output logic            in_service
);

   int_state_t      state_q, state_d;
   logic            ie_q;
   logic [2:0]      idx_q;
   logic [2:0]      win;
   logic            any;
   logic [NSRC-1:0] rise;
   logic [NSRC-1:0] pending_q;
   logic [NSRC-1:0] mask_q;
   logic [NSRC-1:0] eligible;
   logic [NSRC-1:0] clr;

   for (genvar g = 0; g < NSRC; g++) begin : g_src
      sync_edge u_sync (
         .clk   (clk),
         .reset (reset),
         .din   (irq[g]),
         .rise  (rise[g])
      );
   end

   assign eligible = pending_q & ~mask_q;

   // Lowest index wins: first set bit scanning upward.
   always_comb begin
      win = '0;
      any = 1'b0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (eligible[i] && !any) begin
            win = 3'(i);
            any = 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      int_take   = 1'b0;
      pop        = 1'b0;
      in_service = 1'b0;
      case (state_q)
         IDLE: begin
            if (ie_q && any) state_d = TAKE;
         end
         TAKE: begin
            int_take = 1'b1;
            state_d  = SERVICE;
         end
         SERVICE: begin
            in_service = 1'b1;
            if (reti) begin
               pop     = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign clr = int_take ? (NSRC'(1) << idx_q) : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         pending_q <= '0;
         mask_q    <= '1;
         ie_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && state_d == TAKE) idx_q <= win;
         // A new edge on the bit being cleared keeps it set.
         pending_q <= (pending_q & ~clr) | rise;
         if (mask_we) mask_q <= mask_wd;
         // Take/return override ei/di; di wins over ei otherwise.
         if (int_take)  ie_q <= 1'b0;
         else if (pop)  ie_q <= 1'b1;
         else if (di)   ie_q <= 1'b0;
         else if (ei)   ie_q <= 1'b1;
      end
   end

   assign vector    = VEC_BASE + 10'(idx_q) * 10'(VEC_STRIDE);
   assign push      = int_take;
   assign push_data = int_take ? pc_next : '0;
   assign ack       = clr;
   assign mask      = mask_q;
   assign pending   = pending_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed scenarios plus randomized traffic for int_ctrl,
// every cycle compared against a behavioural model of the controller.
module tb_int_ctrl;

   localparam int         NSRC = 4;
   localparam logic [9:0] VB   = 10'h3F0;
   localparam int         VS   = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [NSRC-1:0] irq;
   logic            ei, di, mask_we, reti;
   logic [NSRC-1:0] mask_wd;
   logic [9:0]      pc_next;
   logic            int_take, push, pop, in_service;
   logic [9:0]      vector, push_data;
   logic [NSRC-1:0] ack, mask, pending;

   int checks   = 0;
   int failures = 0;

   // model state
   bit       m_take, m_serv, m_ie;
   bit [3:0] m_pend, m_mask;
   bit [3:0] smp [3];
   int       m_idx;

   always #5 clk = ~clk;

   int_ctrl #(.NSRC(NSRC), .VEC_BASE(VB), .VEC_STRIDE(VS)) dut (
      .clk        (clk),
      .reset      (reset),
      .irq        (irq),
      .ei         (ei),
      .di         (di),
      .mask_we    (mask_we),
      .mask_wd    (mask_wd),
      .reti       (reti),
      .pc_next    (pc_next),
      .int_take   (int_take),
      .vector     (vector),
      .push       (push),
      .push_data  (push_data),
      .pop        (pop),
      .ack        (ack),
      .mask       (mask),
      .pending    (pending),
      .in_service (in_service)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [9:0] exp_vec(input int idx);
      return 10'((int'(VB) + idx * VS) % 1024);
   endfunction

   function automatic int lowest_set(input bit [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic void model_reset();
      m_take = 0; m_serv = 0; m_ie = 0; m_pend = '0; m_mask = '1; m_idx = 0;
      for (int i = 0; i < 3; i++) smp[i] = '0;
   endfunction

   // A level sampled high at edge j-2 after low at j-3 becomes pending at edge j.
   function automatic void model_update();
      bit [3:0] rise, elig, n_pend;
      bit       n_ie;
      rise = smp[1] & ~smp[2];
      elig = m_pend & ~m_mask;
      n_ie = m_ie;
      if (ei) n_ie = 1;
      if (di) n_ie = 0;
      if (m_take) n_ie = 0;
      if (m_serv && reti) n_ie = 1;
      n_pend = m_pend;
      if (m_take) n_pend[m_idx] = 1'b0;
      n_pend |= rise;
      if (mask_we) m_mask = mask_wd;
      if (m_take) begin
         m_take = 0; m_serv = 1;
      end else if (m_serv) begin
         if (reti) m_serv = 0;
      end else if (m_ie && elig != 0) begin
         m_idx = lowest_set(elig); m_take = 1;
      end
      m_ie = n_ie; m_pend = n_pend;
      smp[2] = smp[1]; smp[1] = smp[0]; smp[0] = irq;
   endfunction

   // Called just after a falling edge with inputs set; compares, advances.
   task automatic step();
      #1;
      if (reset) model_reset();
      check("int_take",   int_take,   m_take);
      check("push",       push,       m_take);
      check("pop",        pop,        m_serv && reti);
      check("in_service", in_service, m_serv);
      check("mask",       mask,       m_mask);
      check("pending",    pending,    m_pend);
      check("ack",        ack,        m_take ? (32'd1 << m_idx) : 32'd0);
      check("push_data",  push_data,  m_take ? pc_next : 10'd0);
      if (m_take) check("vector", vector, exp_vec(m_idx));
      if (!reset) model_update();
      @(posedge clk);
      @(negedge clk);
      ei = 0; di = 0; mask_we = 0; reti = 0;
   endtask

   task automatic wait_take(input int maxc, input string tag, input logic [9:0] expv);
      int n = 0;
      while (!int_take && n < maxc) begin
         step();
         n++;
      end
      check({tag, "_taken"}, int_take, 1);
      if (int_take) check({tag, "_vec"}, vector, expv);
   endtask

   initial begin
      int n;
      reset = 1; irq = '0; ei = 0; di = 0; mask_we = 0; mask_wd = '0;
      reti = 0; pc_next = '0;
      #1;
      check("rst_take",    int_take,   0);
      check("rst_pop",     pop,        0);
      check("rst_ack",     ack,        0);
      check("rst_pending", pending,    0);
      check("rst_mask",    mask,       4'hF);
      check("rst_vector",  vector,     10'h3F0);
      check("rst_insvc",   in_service, 0);
      model_reset();
      @(negedge clk);
      step();
      reset = 0;

      // basic take with latency and stack push
      ei = 1; mask_we = 1; mask_wd = '0; step();
      repeat (3) step();
      pc_next = 10'h045; irq[2] = 1; step(); irq[2] = 0;
      repeat (3) step();
      #1;
      check("lat_take",      int_take,  1);
      check("lat_vector",    vector,    10'h3F8);
      check("lat_push_data", push_data, 10'h045);
      check("lat_ack",       ack,       4'b0100);
      step();
      check("pend2_clr", pending[2], 0);
      reti = 1; step(); step();

      // simultaneous requests: lower index first, then the other after reti
      irq[1] = 1; irq[3] = 1;
      wait_take(8, "prio1", 10'h3F4);
      step(); step();
      reti = 1; #1; check("prio_pop", pop, 1); step();
      wait_take(2, "prio3", 10'h3FC);
      step(); reti = 1; step(); irq = '0;

      // masking holds the request pending; unmasking releases it
      mask_we = 1; mask_wd = 4'b0001; step();
      irq[0] = 1; repeat (6) step();
      check("mask_hold_pend", pending[0], 1);
      check("mask_hold_take", int_take,   0);
      mask_we = 1; mask_wd = '0; step();
      wait_take(3, "unmask", 10'h3F0);
      step(); reti = 1; step(); irq = '0;

      // reti outside service; edge during service held until return
      repeat (3) step();
      reti = 1; #1; check("reti_idle_pop", pop, 0); step();
      check("reti_idle_svc", in_service, 0);
      irq[2] = 1; wait_take(8, "svc_a", 10'h3F8); step();
      irq[2] = 0; repeat (2) step(); irq[2] = 1; repeat (5) step();
      check("svc_pend2",   pending[2], 1);
      check("svc_no_take", int_take,   0);
      reti = 1; step();
      wait_take(2, "svc_b", 10'h3F8);
      step(); reti = 1; step(); irq = '0;

      // ei and di together leave interrupts disabled
      di = 1; step();
      irq[1] = 1; repeat (5) step();
      ei = 1; di = 1; step();
      n = 0;
      repeat (6) begin
         if (int_take) n++;
         step();
      end
      check("eidi_no_take", n, 0);
      check("eidi_pend1",   pending[1], 1);
      ei = 1; step();
      wait_take(2, "eidi_after", 10'h3F4);
      step();

      // asynchronous reset in service with a request pending
      irq[1] = 0; repeat (2) step(); irq[1] = 1; repeat (5) step();
      check("pre_rst_pend1", pending[1], 1);
      check("pre_rst_svc",   in_service, 1);
      reset = 1; #1;
      check("arst_svc",  in_service, 0);
      check("arst_pend", pending,    0);
      check("arst_mask", mask,       4'hF);
      irq = '0;
      step();
      reset = 0;

      // randomized traffic
      repeat (3000) begin
         for (int i = 0; i < NSRC; i++) if ($urandom_range(0, 7) == 0) irq[i] = ~irq[i];
         ei      = ($urandom_range(0, 3) == 0);
         di      = ($urandom_range(0, 15) == 0);
         mask_we = ($urandom_range(0, 15) == 0);
         mask_wd = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
         reti    = ($urandom_range(0, 4) == 0);
         pc_next = 10'($urandom);
         reset   = ($urandom_range(0, 499) == 0);
         step();
         reset = 0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
